// File: rtl/dmem_boot_arbiter.sv
// dmem_boot_arbiter: owns the data memory port; sequences boot (loader fills memory, CPU held in reset)
// and, once running, arbitrates each cycle between the CPU and the external port with starvation protection.
module dmem_boot_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int RELEASE_CYCLES = 4,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_ext_req,
   input  logic          i_ext_we,
   input  logic [AW-1:0] i_ext_addr,
   input  logic [DW-1:0] i_ext_wdata,
   input  logic          i_ext_done,
   output logic          o_ext_gnt,
   output logic [DW-1:0] o_ext_rdata,
   input  logic          i_cpu_en,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [DW-1:0] i_cpu_wdata,
   input  logic [2:0]    i_cpu_funct3,
   output logic [DW-1:0] o_cpu_rdata,
   output logic          o_cpu_stall,
   output logic          o_cpu_rst_n,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   output logic [2:0]    o_mem_funct3,
   input  logic [DW-1:0] i_mem_rdata,
   output logic [15:0]   o_boot_words,
   output logic [1:0]    o_state
);
   localparam int WW = $clog2(STARVE_LIMIT + 1);
   localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_BOOT  = 2'b00,
      S_DRAIN = 2'b01,
      S_RUN   = 2'b10
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [RW-1:0] r_rel_cnt, w_rel_cnt_nxt;
   logic [WW-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic [15:0]   r_boot_words;
   logic          r_cpu_rst_n;
   logic          w_run, w_starve, w_ext_own;

   // Outside RUN the external port owns memory unconditionally.
   always_comb begin
      w_run        = (r_state == S_RUN);
      w_starve     = i_ext_req && (r_wait_cnt == WW'(STARVE_LIMIT));
      o_ext_gnt    = w_run ? (i_ext_req && (!i_cpu_en || w_starve)) : i_ext_req;
      o_cpu_stall  = w_run && i_cpu_en && o_ext_gnt;
      w_ext_own    = !w_run || o_ext_gnt;
      o_mem_we     = w_ext_own ? (i_ext_req && i_ext_we) : (i_cpu_en && i_cpu_we);
      o_mem_addr   = w_ext_own ? i_ext_addr : i_cpu_addr;
      o_mem_wdata  = w_ext_own ? i_ext_wdata : i_cpu_wdata;
      o_mem_funct3 = w_ext_own ? 3'b010 : i_cpu_funct3;
      o_ext_rdata  = i_mem_rdata;
      o_cpu_rdata  = i_mem_rdata;
      o_cpu_rst_n  = r_cpu_rst_n;
      o_boot_words = r_boot_words;
      o_state      = r_state;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rel_cnt_nxt = r_rel_cnt;
      unique case (r_state)
         S_BOOT: begin
            if (i_ext_done) begin
               w_state_nxt   = S_DRAIN;
               w_rel_cnt_nxt = RW'(RELEASE_CYCLES - 1);
            end
         end
         S_DRAIN: begin
            if (r_rel_cnt == '0) w_state_nxt = S_RUN;
            else w_rel_cnt_nxt = r_rel_cnt - 1'b1;
         end
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = S_BOOT;
      endcase
      w_wait_cnt_nxt = (!w_run || !i_ext_req || o_ext_gnt) ? '0 :
                       (r_wait_cnt == WW'(STARVE_LIMIT)) ? r_wait_cnt : r_wait_cnt + 1'b1;
   end

   // cpu_rst_n is registered from the next state so it rises glitch-free on the RUN entry edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_BOOT;
         r_rel_cnt    <= '0;
         r_wait_cnt   <= '0;
         r_boot_words <= '0;
         r_cpu_rst_n  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rel_cnt    <= w_rel_cnt_nxt;
         r_wait_cnt   <= w_wait_cnt_nxt;
         r_cpu_rst_n  <= (w_state_nxt == S_RUN);
         if (r_state == S_BOOT && o_mem_we && r_boot_words != 16'hFFFF)
            r_boot_words <= r_boot_words + 16'd1;
      end
   end
endmodule

// File: doc/dmem_boot_arbiter.md
# dmem_boot_arbiter

Owner of the single-port data memory in the RV32 single-cycle system. It sequences boot: the CPU is held in reset while an external loader fills memory, then released after a fixed drain delay. In run mode it arbitrates every memory cycle between the CPU's load/store port and the external debug/loader port, with starvation protection. It sits between `riscv_cpu`, the external port and `data_mem`.

## Interface
- AW, 32, address width
- DW, 32, data width
- RELEASE_CYCLES, 4, cycles CPU reset stays asserted after `ext_done` (≥1)
- STARVE_LIMIT, 8, max RUN cycles an external request may wait before forcing a CPU stall (≥1)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- ext_req  in  1  external port requests a memory cycle
- ext_we  in  1  external request is a write
- ext_addr  in  AW  external byte address
- ext_wdata  in  DW  external write data
- ext_done  in  1  one-cycle pulse: boot image load complete
- ext_gnt  out  1  external access performed this cycle
- ext_rdata  out  DW  read data to external port (valid when ext_gnt)
- cpu_en  in  1  CPU executes a load/store this cycle
- cpu_we  in  1  CPU store
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU store data
- cpu_funct3  in  3  CPU access size/sign
- cpu_rdata  out  DW  load data to CPU
- cpu_stall  out  1  CPU must not retire this cycle (PC, regfile, store suppressed)
- cpu_rst_n  out  1  active-low reset to `riscv_cpu`
- mem_we  out  1  write enable to `data_mem`
- mem_addr  out  AW  address to `data_mem`
- mem_wdata  out  DW  write data to `data_mem`
- mem_funct3  out  3  size to `data_mem`; 3'b010 (word) for external accesses
- mem_rdata  in  DW  read data from `data_mem` (combinational)
- boot_words  out  16  count of external writes performed in BOOT, saturating at 16'hFFFF
- state_o  out  2  current state (00 BOOT, 01 DRAIN, 10 RUN)

## Operation
- States: BOOT, DRAIN, RUN. Reset → BOOT.
- BOOT: `cpu_rst_n`=0; external port owns memory: `ext_gnt`=`ext_req`, mux selects external. Each granted write increments `boot_words` (saturating). `ext_done`=1 → DRAIN, loading release counter with RELEASE_CYCLES-1. A granted access in the same cycle as `ext_done` completes normally.
- DRAIN: `cpu_rst_n`=0; external still owns memory as in BOOT. Counter decrements each cycle; at 0 → RUN. `ext_done` ignored.
- RUN: `cpu_rst_n`=1. Owner selection per cycle (combinational from registered state):
  - starve = `ext_req` && (wait_cnt == STARVE_LIMIT).
  - `ext_gnt` = `ext_req` && (!`cpu_en` || starve).
  - `cpu_stall` = `cpu_en` && `ext_gnt`.
  - Owner external if `ext_gnt`, else CPU.
- wait_cnt (width clog2(STARVE_LIMIT+1)): RUN only; cleared when `ext_req`=0 or `ext_gnt`=1; else increments; never exceeds STARVE_LIMIT. Held at 0 outside RUN.
- Mux: `mem_addr`/`mem_wdata`/`mem_funct3` from owner; `mem_we` = owner write (`ext_we` on grant, `cpu_we`&&`cpu_en`&&!`cpu_stall` for CPU; 0 when no requester). Non-owner address/data may be don't-care but `mem_we` must be exact.
- `cpu_rdata` = `ext_rdata` = `mem_rdata` (both driven; validity qualified by owner).
- `ext_done` in RUN ignored; return to BOOT only via `reset`.

## Timing
- Reset values: state BOOT, `cpu_rst_n`=0, `cpu_stall`=0, `boot_words`=0, `state_o`=00, wait_cnt=0, release counter=0; `ext_gnt`/`mem_we` follow BOOT combinational rules (0 while `ext_req`=0).
- Grant, stall and mux outputs are combinational, same cycle as request; memory write commits at the following rising edge.
- `cpu_rst_n` rises exactly RELEASE_CYCLES cycles after the edge sampling `ext_done`; `cpu_rst_n` is registered (no glitches).
- Reset asserted mid-RUN: `cpu_rst_n` low and state BOOT immediately (asynchronous); any in-flight write not committed.
- Worst-case external latency in RUN: STARVE_LIMIT+1 cycles from `ext_req` rise.

## Test plan
- Boot load: reset release, 5 external writes (addr 0x0..0x10, data 0xA0..0xA4), `ext_done` pulse → `boot_words`=5, `cpu_rst_n` rises 4 cycles after `ext_done`, readback returns 0xA0..0xA4.
- Idle-CPU sharing: RUN, `cpu_en`=0, `ext_req`=1 read of 0x8 → `ext_gnt`=1 same cycle, `cpu_stall`=0, `ext_rdata`=mem[0x8].
- Starvation: RUN, `cpu_en`=1 continuously, `ext_req`=1 write 0x55 to 0x40 → `ext_gnt`=0 for 8 cycles, 9th cycle `ext_gnt`=1, `cpu_stall`=1, CPU store suppressed, wait_cnt back to 0.
- Simultaneous CPU store and external read with wait_cnt<8 → CPU store commits, `ext_gnt`=0, `mem_we`=1 with CPU address.
- Reset mid-DRAIN and mid-RUN → `state_o`=00, `cpu_rst_n`=0, `boot_words`=0 asynchronously, before next clock edge.
- `ext_done` in RUN and 70000 boot writes → state stays RUN; `boot_words` saturates at 0xFFFF.
